// File: rtl/maze_collect_engine.sv
// -----------------------------------------------------------------------------
// maze_collect_engine
//
// Game-logic core for the maze collector. It owns the player position, the
// per-item collected flags, trap collisions, the life counter and the game
// state machine. Everything advances only on an internal game tick produced
// by a free-running divider, so the whole game runs at a human pace while the
// renderers downstream sample the registered outputs at board_clk rate.
//
// Level geometry is not stored here: item points and trap rectangles arrive
// as packed vectors from a ROM or constants, so any layout can be played.
//
// Optional build macro:
//   MAZE_COLLECT_TIMER_EN  - adds a per-game tick budget (TIME_LIMIT). When
//                            undefined, o_time_left is constant 0 and a game
//                            never runs out of time.
//
// Ports:
//   board_clk      in   system clock
//   reset          in   asynchronous, active-high reset
//   i_start        in   level; begin a game (sampled on a tick in IDLE)
//   i_ack          in   level; acknowledge OVER/WIN (sampled on a tick)
//   i_btn_u/d/l/r  in   synchronised direction buttons
//   i_item_xy      in   item i at [i*2W +: 2W] as {y,x}, x in the low bits
//   i_trap_rect    in   trap i at [i*4W +: 4W] as {y1,x1,y0,x0}, inclusive
//   o_tick         out  one-cycle game-tick pulse
//   o_state        out  IDLE=0, PLAY=1, HIT=2, OVER=3, WIN=4
//   o_player_x/y   out  player centre
//   o_collected    out  per-item collected flags (sticky until IDLE)
//   o_score        out  popcount of o_collected
//   o_lives_left   out  remaining lives
//   o_time_left    out  remaining ticks (0 without the timer macro)
// -----------------------------------------------------------------------------
module maze_collect_engine #(
  parameter int COORD_W    = 10,
  parameter int N_ITEMS    = 4,
  parameter int N_TRAPS    = 4,
  parameter int TICK_DIV   = 21,
  parameter int STEP       = 4,
  parameter int HALF       = 10,
  parameter int X_MIN      = 60,
  parameter int X_MAX      = 560,
  parameter int Y_MIN      = 60,
  parameter int Y_MAX      = 460,
  parameter int START_X    = 320,
  parameter int START_Y    = 70,
  parameter int LIVES      = 3,
  parameter int HIT_TICKS  = 16,
  parameter int TIME_LIMIT = 1024
) (
  input  logic                           board_clk,
  input  logic                           reset,
  input  logic                           i_start,
  input  logic                           i_ack,
  input  logic                           i_btn_u,
  input  logic                           i_btn_d,
  input  logic                           i_btn_l,
  input  logic                           i_btn_r,
  input  logic [N_ITEMS*2*COORD_W-1:0]   i_item_xy,
  input  logic [N_TRAPS*4*COORD_W-1:0]   i_trap_rect,
  output logic                           o_tick,
  output logic [2:0]                     o_state,
  output logic [COORD_W-1:0]             o_player_x,
  output logic [COORD_W-1:0]             o_player_y,
  output logic [N_ITEMS-1:0]             o_collected,
  output logic [3:0]                     o_score,
  output logic [2:0]                     o_lives_left,
  output logic [15:0]                    o_time_left
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_HIT  = 3'd2,
    S_OVER = 3'd3,
    S_WIN  = 3'd4
  } state_t;

`ifdef MAZE_COLLECT_TIMER_EN
  localparam bit TIMER_ON = 1'b1;
`else
  localparam bit TIMER_ON = 1'b0;
`endif

  // Geometry comparisons use one extra bit so p+HALF and x1+HALF never wrap.
  localparam int EW = COORD_W + 1;

  localparam logic [EW-1:0]      HALF_E    = EW'(HALF);
  localparam logic [EW-1:0]      STEP_E    = EW'(STEP);
  localparam logic [EW-1:0]      X_MIN_E   = EW'(X_MIN);
  localparam logic [EW-1:0]      X_MAX_E   = EW'(X_MAX);
  localparam logic [EW-1:0]      Y_MIN_E   = EW'(Y_MIN);
  localparam logic [EW-1:0]      Y_MAX_E   = EW'(Y_MAX);
  localparam logic [COORD_W-1:0] STEP_C    = COORD_W'(STEP);
  localparam logic [COORD_W-1:0] X_MIN_C   = COORD_W'(X_MIN);
  localparam logic [COORD_W-1:0] X_MAX_C   = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] Y_MIN_C   = COORD_W'(Y_MIN);
  localparam logic [COORD_W-1:0] Y_MAX_C   = COORD_W'(Y_MAX);
  localparam logic [COORD_W-1:0] START_X_C = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] START_Y_C = COORD_W'(START_Y);
  localparam logic [2:0]         LIVES_C   = 3'(LIVES);

  // Without the timer the reload value folds to 0, which ties time_left low.
  localparam logic [15:0] TIME_INIT = 16'(TIME_LIMIT) & {16{TIMER_ON}};

  // The freeze counter is loaded with HIT_TICKS-1 and leaves HIT on the tick
  // that finds it at zero, giving exactly HIT_TICKS ticks in HIT.
  localparam int              HC_W     = (HIT_TICKS > 1) ? $clog2(HIT_TICKS) : 1;
  localparam logic [HC_W-1:0] HIT_LOAD = HC_W'(HIT_TICKS - 1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [TICK_DIV-1:0] r_div;
  logic                r_tick;
  state_t              r_state;
  logic [COORD_W-1:0]  r_x;
  logic [COORD_W-1:0]  r_y;
  logic [N_ITEMS-1:0]  r_coll;
  logic [3:0]          r_score;
  logic [2:0]          r_lives;
  logic [HC_W-1:0]     r_hit_cnt;
  logic [15:0]         r_time;

  // ---------------------------------------------------------------------------
  // Next-state wires
  // ---------------------------------------------------------------------------
  state_t              w_state_nx;
  logic [COORD_W-1:0]  w_x_nx;
  logic [COORD_W-1:0]  w_y_nx;
  logic [N_ITEMS-1:0]  w_coll_nx;
  logic [2:0]          w_lives_nx;
  logic [HC_W-1:0]     w_hit_nx;
  logic [15:0]         w_time_nx;
  logic [15:0]         w_time_dec;

  logic [COORD_W-1:0]  w_x_mv;
  logic [COORD_W-1:0]  w_y_mv;
  logic [EW-1:0]       w_px_e;
  logic [EW-1:0]       w_py_e;
  logic [N_TRAPS-1:0]  w_trap_ovl;
  logic [N_ITEMS-1:0]  w_item_near;
  logic                w_trap_any;

  function automatic logic [3:0] popcount(input logic [N_ITEMS-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < N_ITEMS; i++) begin
      c = c + 4'(v[i]);
    end
    return c;
  endfunction

  assign w_px_e = {1'b0, r_x};
  assign w_py_e = {1'b0, r_y};

  // ---------------------------------------------------------------------------
  // Trap overlap: player box [p-HALF, p+HALF] against an inclusive rectangle,
  // rearranged so nothing is ever subtracted.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_TRAPS; gi++) begin : g_trap
    logic [EW-1:0] w_x0;
    logic [EW-1:0] w_y0;
    logic [EW-1:0] w_x1;
    logic [EW-1:0] w_y1;

    assign w_x0 = {1'b0, i_trap_rect[gi*4*COORD_W             +: COORD_W]};
    assign w_y0 = {1'b0, i_trap_rect[gi*4*COORD_W +   COORD_W +: COORD_W]};
    assign w_x1 = {1'b0, i_trap_rect[gi*4*COORD_W + 2*COORD_W +: COORD_W]};
    assign w_y1 = {1'b0, i_trap_rect[gi*4*COORD_W + 3*COORD_W +: COORD_W]};

    assign w_trap_ovl[gi] = (w_px_e + HALF_E >= w_x0) && (w_px_e <= w_x1 + HALF_E) &&
                            (w_py_e + HALF_E >= w_y0) && (w_py_e <= w_y1 + HALF_E);
  end

  assign w_trap_any = |w_trap_ovl;

  // ---------------------------------------------------------------------------
  // Item pickup: |i-p| <= HALF on both axes, written as two one-sided bounds.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_ITEMS; gi++) begin : g_item
    logic [EW-1:0] w_ix;
    logic [EW-1:0] w_iy;

    assign w_ix = {1'b0, i_item_xy[gi*2*COORD_W           +: COORD_W]};
    assign w_iy = {1'b0, i_item_xy[gi*2*COORD_W + COORD_W +: COORD_W]};

    assign w_item_near[gi] = (w_ix + HALF_E >= w_px_e) && (w_px_e + HALF_E >= w_ix) &&
                             (w_iy + HALF_E >= w_py_e) && (w_py_e + HALF_E >= w_iy);
  end

  // ---------------------------------------------------------------------------
  // Movement with saturation. The bound tests happen before the step so the
  // result is clamped rather than wrapped.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    w_x_mv = r_x;
    w_y_mv = r_y;

    if (i_btn_l && !i_btn_r) begin
      w_x_mv = (w_px_e < X_MIN_E + STEP_E) ? X_MIN_C : r_x - STEP_C;
    end else if (i_btn_r && !i_btn_l) begin
      w_x_mv = (w_px_e + STEP_E > X_MAX_E) ? X_MAX_C : r_x + STEP_C;
    end

    if (i_btn_u && !i_btn_d) begin
      w_y_mv = (w_py_e < Y_MIN_E + STEP_E) ? Y_MIN_C : r_y - STEP_C;
    end else if (i_btn_d && !i_btn_u) begin
      w_y_mv = (w_py_e + STEP_E > Y_MAX_E) ? Y_MAX_C : r_y + STEP_C;
    end
  end

  assign w_time_dec = (r_time != 16'd0) ? r_time - 16'd1 : 16'd0;

  // ---------------------------------------------------------------------------
  // Next-state and datapath decisions for one game tick.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nx = r_state;
    w_x_nx     = r_x;
    w_y_nx     = r_y;
    w_coll_nx  = r_coll;
    w_lives_nx = r_lives;
    w_hit_nx   = r_hit_cnt;
    w_time_nx  = r_time;

    unique case (r_state)
      S_IDLE: begin
        w_x_nx     = START_X_C;
        w_y_nx     = START_Y_C;
        w_coll_nx  = '0;
        w_lives_nx = LIVES_C;
        w_time_nx  = TIME_INIT;
        if (i_start) begin
          w_state_nx = S_PLAY;
        end
      end

      S_PLAY: begin
        if (TIMER_ON) begin
          w_time_nx = w_time_dec;
        end

        // Trap wins over everything: this tick's move and pickup are dropped.
        if (w_trap_any) begin
          if (r_lives <= 3'd1) begin
            w_lives_nx = 3'd0;
            w_state_nx = S_OVER;
          end else begin
            w_lives_nx = r_lives - 3'd1;
            w_state_nx = S_HIT;
            w_hit_nx   = HIT_LOAD;
            w_x_nx     = START_X_C;
            w_y_nx     = START_Y_C;
          end
        end else begin
          w_coll_nx = r_coll | w_item_near;
          w_x_nx    = w_x_mv;
          w_y_nx    = w_y_mv;
          if (&w_coll_nx) begin
            w_state_nx = S_WIN;
          end else if (TIMER_ON && (w_time_dec == 16'd0)) begin
            w_state_nx = S_OVER;
          end
        end
      end

      S_HIT: begin
        if (r_hit_cnt == '0) begin
          w_state_nx = S_PLAY;
        end else begin
          w_hit_nx = r_hit_cnt - 1'b1;
        end
      end

      S_OVER, S_WIN: begin
        if (i_ack) begin
          w_state_nx = S_IDLE;
          w_x_nx     = START_X_C;
          w_y_nx     = START_Y_C;
          w_coll_nx  = '0;
          w_lives_nx = LIVES_C;
          w_time_nx  = TIME_INIT;
        end
      end

      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Tick divider: o_tick is high for the single cycle in which r_div is 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      // NOTE: sequential state is written with non-blocking assignments so
      // every flop samples the values from before this edge.
      r_div  <= r_div + 1'b1;
      r_tick <= (r_div == '1);
    end
  end

  // State register.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else if (r_tick) begin
      r_state <= w_state_nx;
    end
  end

  // Game datapath, advanced only in tick cycles.
  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      r_x       <= START_X_C;
      r_y       <= START_Y_C;
      r_coll    <= '0;
      r_score   <= '0;
      r_lives   <= LIVES_C;
      r_hit_cnt <= '0;
      r_time    <= TIME_INIT;
    end else if (r_tick) begin
      r_x       <= w_x_nx;
      r_y       <= w_y_nx;
      r_coll    <= w_coll_nx;
      r_score   <= popcount(w_coll_nx);
      r_lives   <= w_lives_nx;
      r_hit_cnt <= w_hit_nx;
      r_time    <= w_time_nx;
    end
  end

  assign o_tick       = r_tick;
  assign o_state      = r_state;
  assign o_player_x   = r_x;
  assign o_player_y   = r_y;
  assign o_collected  = r_coll;
  assign o_score      = r_score;
  assign o_lives_left = r_lives;
  assign o_time_left  = r_time;

endmodule
